// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame writer: FSM encoding, init command ROM,
// HD44780 command constants and line-2 start index.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        SEL_SET,
        FETCH,
        SETUP,
        E_HI,
        HOLD,
        NEXT
    } state_t;

    localparam int         CNT_W     = 21;
    localparam int         INIT_CNT  = 6;
    localparam logic [7:0] LCD_CLR   = 8'h01;
    localparam logic [7:0] LCD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_LINE2 = 8'hC0;
    localparam logic [5:0] LINE2_IDX = 6'd17;

    // Power-on command sequence: 8-bit/2-line function set (x3), display on,
    // clear, entry mode increment.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = 8'h38;
            3'd3:             b = 8'h0C;
            3'd4:             b = LCD_CLR;
            default:          b = 8'h06;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_bus_strobe.sv
// One HD44780 bus write: RS/DB setup, E high pulse, then post-write gap.
// Emits a single-cycle done at the end of the gap; accepts start only when idle.
module lcd_bus_strobe
    import lcd_pkg::*;
#(
    parameter int T_AS  = 8,
    parameter int T_EH  = 50,
    parameter int T_GAP = 4_000,
    parameter int T_CLR = 164_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] db,
    input  logic       gap_sel,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_db
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             gap_q, gap_d;
    logic             e_q;

    // Phase sequencing and countdown; RS/DB only change when a new write is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        db_d    = db_q;
        gap_d   = gap_q;
        done    = 1'b0;
        case (state_q)
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = E_HI;
                    cnt_d   = CNT_W'(T_EH - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            E_HI: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = gap_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_GAP - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    rs_d    = rs;
                    db_d    = db;
                    gap_d   = gap_sel;
                    cnt_d   = CNT_W'(T_AS - 1);
                    state_d = SETUP;
                end
            end
        endcase
    end

    // State/holding registers; E is registered from the next state so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            gap_q   <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            gap_q   <= gap_d;
            e_q     <= (state_d == E_HI);
        end
    end

    assign lcd_e  = e_q;
    assign lcd_rs = rs_q;
    assign lcd_db = db_q;

endmodule

// File: rtl/lcd_frame_writer.sv
// HD44780 2x16 frame writer: power-on init, then walks sel 0..SEL_LAST over the
// command_lookup table and writes each returned byte to the LCD.
// Optional macro LCD_AUTO_REFRESH_EN adds a periodic refresh while idle.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int T_PWR    = 1_500_000,
    parameter int T_AS     = 8,
    parameter int T_EH     = 50,
    parameter int T_GAP    = 4_000,
    parameter int T_CLR    = 164_000,
    parameter int SEL_LAT  = 2,
    parameter int SEL_LAST = 33,
    parameter int T_REF    = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       buffer_ready,
    output logic [5:0] sel,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       init_done,
    output logic       busy,
    output logic       frame_done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwr_arm_q, pwr_arm_d;
    logic [2:0]       idx_q, idx_d;
    logic             wr_wait_q, wr_wait_d;
    logic             pend_q, pend_d;
    logic             br_q;
    logic [5:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;

    logic             st_start, st_rs, st_gap, st_done;
    logic [7:0]       st_db;
    logic             pend_clr, init_fin, ref_hit;

`ifdef LCD_AUTO_REFRESH_EN
    logic [23:0] ref_cnt_q, ref_cnt_d;

    // Idle-time refresh timer; restarts whenever a frame is launched.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        ref_hit   = 1'b0;
        if (state_q == IDLE) begin
            if (pend_q) begin
                ref_cnt_d = '0;
            end else if (ref_cnt_q == 24'(T_REF - 1)) begin
                ref_cnt_d = '0;
                ref_hit   = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 24'd1;
            end
        end
    end

    // Refresh timer register.
    always_ff @(posedge clk) begin
        if (rst) ref_cnt_q <= '0;
        else     ref_cnt_q <= ref_cnt_d;
    end
`else
    assign ref_hit = 1'b0;
`endif

    // Init and frame sequencing; the bus strobe does the per-write timing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pwr_arm_d    = pwr_arm_q;
        idx_d        = idx_q;
        wr_wait_d    = wr_wait_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        st_start     = 1'b0;
        st_rs        = 1'b0;
        st_db        = '0;
        st_gap       = 1'b0;
        pend_clr     = 1'b0;
        init_fin     = 1'b0;
        case (state_q)
            PWR_WAIT: begin
                // First cycle loads the counter, so the load value is T_PWR-2.
                if (!pwr_arm_q) begin
                    cnt_d     = CNT_W'(T_PWR - 2);
                    pwr_arm_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = INIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INIT: begin
                st_db  = init_rom(idx_q);
                st_gap = (st_db == LCD_CLR);
                if (!wr_wait_q) begin
                    st_start  = 1'b1;
                    wr_wait_d = 1'b1;
                end else if (st_done) begin
                    wr_wait_d = 1'b0;
                    if (idx_q == 3'(INIT_CNT - 1)) begin
                        idx_d       = '0;
                        init_done_d = 1'b1;
                        init_fin    = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            IDLE: begin
                if (pend_q) begin
                    pend_clr = 1'b1;
                    busy_d   = 1'b1;
                    sel_d    = '0;
                    state_d  = SEL_SET;
                end
            end
            SEL_SET: begin
                cnt_d   = CNT_W'(SEL_LAT - 1);
                state_d = FETCH;
            end
            FETCH: begin
                if (cnt_q == '0) begin
                    // Indices 0 and 17 carry the DDRAM address commands.
                    st_start = 1'b1;
                    st_db    = data_in;
                    st_rs    = !((sel_q == 6'd0) || (sel_q == LINE2_IDX));
                    state_d  = SETUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETUP: begin
                if (st_done) state_d = NEXT;
            end
            NEXT: begin
                if (sel_q == 6'(SEL_LAST)) begin
                    sel_d        = '0;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    sel_d   = sel_q + 6'd1;
                    state_d = SEL_SET;
                end
            end
            default: state_d = PWR_WAIT;
        endcase

        // A set request on the clearing cycle wins, so no edge is lost.
        pend_d = pend_q;
        if (pend_clr) pend_d = 1'b0;
        if ((buffer_ready && !br_q) || init_fin || ref_hit) pend_d = 1'b1;
    end

    // Control registers; reset aborts everything and reruns power-on init.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            pwr_arm_q    <= 1'b0;
            idx_q        <= '0;
            wr_wait_q    <= 1'b0;
            pend_q       <= 1'b0;
            br_q         <= 1'b0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwr_arm_q    <= pwr_arm_d;
            idx_q        <= idx_d;
            wr_wait_q    <= wr_wait_d;
            pend_q       <= pend_d;
            br_q         <= buffer_ready;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    lcd_bus_strobe #(
        .T_AS  (T_AS),
        .T_EH  (T_EH),
        .T_GAP (T_GAP),
        .T_CLR (T_CLR)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .start   (st_start),
        .rs      (st_rs),
        .db      (st_db),
        .gap_sel (st_gap),
        .done    (st_done),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_db  (lcd_db)
    );

    assign sel        = sel_q;
    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer with a two-stage command_lookup model
// returning sel+0x40. Build with LCD_AUTO_REFRESH_EN to exercise auto-refresh.
module tb_lcd_frame_writer;

    localparam int T_PWR    = 20;
    localparam int T_AS     = 2;
    localparam int T_EH     = 4;
    localparam int T_GAP    = 10;
    localparam int T_CLR    = 30;
    localparam int SEL_LAT  = 2;
    localparam int SEL_LAST = 33;
    localparam int T_REF    = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in;
    logic       buffer_ready = 1'b0;
    logic [5:0] sel;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, busy, frame_done;
    logic [7:0] lcd_db;

    lcd_frame_writer #(
        .T_PWR(T_PWR), .T_AS(T_AS), .T_EH(T_EH), .T_GAP(T_GAP), .T_CLR(T_CLR),
        .SEL_LAT(SEL_LAT), .SEL_LAST(SEL_LAST), .T_REF(T_REF)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .buffer_ready(buffer_ready),
        .sel(sel), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_db(lcd_db), .init_done(init_done), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // command_lookup model: byte valid SEL_LAT cycles after sel changes
    logic [7:0] m1 = 8'h00, m2 = 8'h00;
    always @(posedge clk) begin
        m1 <= {2'b00, sel} + 8'h40;
        m2 <= m1;
    end
    assign data_in = m2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor, sampled on the falling edge
    logic       e_prev = 1'b0;
    logic [7:0] q_db[$];
    logic       q_rs[$];
    logic [5:0] q_sel[$];
    int         q_rise[$];
    int         q_fall[$];
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            q_db.push_back(lcd_db);
            q_rs.push_back(lcd_rs);
            q_sel.push_back(sel);
            q_rise.push_back(cyc);
        end
        if (!lcd_e && e_prev) q_fall.push_back(cyc);
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        e_prev = lcd_e;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] ROM [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input int target, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fd_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    // rel = cycle in which rst was dropped; the first edge sampling rst low
    // is t0, and E must rise T_PWR+T_AS edges after t0.
    task automatic check_init(input int base, input int rel);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("init_done_timeout", {31'd0, ok}, 32'd1);
        chk("init_pulse_count", q_rise.size() - base, 32'd6);
        if (q_rise.size() >= base + 6 && q_fall.size() >= base + 6) begin
            chk("init_first_e_rise", q_rise[base] - rel, 1 + T_PWR + T_AS);
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("init_db_%0d", i), q_db[base+i], ROM[i]);
                chk($sformatf("init_rs_%0d", i), q_rs[base+i], 1'b0);
                chk($sformatf("init_e_width_%0d", i), q_fall[base+i] - q_rise[base+i], T_EH);
            end
            // E-low span = gap + one idle cycle + setup
            chk("init_gap_normal", q_rise[base+1] - q_fall[base], T_GAP + 1 + T_AS);
            chk("init_gap_clear", q_rise[base+5] - q_fall[base+4], T_CLR + 1 + T_AS);
        end
    endtask

    initial begin
        int base, fd0, rel, t;
        bit ok;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_lcd_e", lcd_e, 1'b0);
        chk("rst_sel", sel, 6'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_lcd_db", lcd_db, 8'h00);
        chk("rst_lcd_rs", lcd_rs, 1'b0);
        chk("rst_lcd_rw", lcd_rw, 1'b0);

        // power-on init
        rst = 1'b0;
        rel = cyc;
        check_init(0, rel);

        // automatic first frame
        base = 6;
        wait_fd(1, 2000, "frame1_timeout");
        chk("frame1_pulses", q_rise.size() - base, 32'd34);
        if (q_rise.size() >= base + 34) begin
            for (int i = 0; i < 34; i++) begin
                chk($sformatf("f1_sel_%0d", i), q_sel[base+i], i);
                chk($sformatf("f1_db_%0d", i), q_db[base+i], 8'h40 + i);
                chk($sformatf("f1_rs_%0d", i), q_rs[base+i], (i != 0 && i != 17));
            end
        end
        chk("frame1_sel_back_0", sel, 6'd0);
        chk("frame1_busy_clear", busy, 1'b0);
        chk("frame1_fd_count", fd_cnt, 32'd1);
        @(negedge clk);
        chk("frame_done_one_cycle", frame_done, 1'b0);

        // three edges mid-frame -> exactly one follow-up frame
        base = q_rise.size();
        fd0  = fd_cnt;
        buffer_ready = 1'b1; @(negedge clk);
        buffer_ready = 1'b0; @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (sel == 6'd5) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_sel5", {31'd0, ok}, 32'd1);
        repeat (3) begin
            buffer_ready = 1'b1; @(negedge clk);
            buffer_ready = 1'b0; @(negedge clk);
        end
        wait_fd(fd0 + 2, 4000, "midframe_timeout");
        repeat (100) @(negedge clk);
        chk("midframe_fd_count", fd_cnt, fd0 + 2);
        chk("midframe_pulses", q_rise.size() - base, 32'd68);
        chk("midframe_idle", busy, 1'b0);
        if (q_db.size() > 0) chk("midframe_last_db", q_db[q_db.size()-1], 8'h61);

        // held-high buffer_ready -> one frame only
        base = q_rise.size();
        fd0  = fd_cnt;
        buffer_ready = 1'b1;
        repeat (1000) @(negedge clk);
        chk("held_fd_count", fd_cnt, fd0 + 1);
        chk("held_pulses", q_rise.size() - base, 32'd34);
        chk("held_idle", busy, 1'b0);
        buffer_ready = 1'b0;
        @(negedge clk);

`ifdef LCD_AUTO_REFRESH_EN
        // refresh frame starts T_REF cycles after frame_done; busy rises one cycle later
        fd0 = fd_cnt;
        wait_fd(fd0 + 1, 3000, "refresh_fd_timeout");
        t  = fd_cyc;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("refresh_busy_timeout", {31'd0, ok}, 32'd1);
        chk("refresh_interval", cyc - t, T_REF + 1);
`else
        // no spontaneous frames without buffer_ready
        fd0  = fd_cnt;
        base = q_rise.size();
        repeat (700) @(negedge clk);
        chk("no_auto_frame", fd_cnt, fd0);
        chk("no_auto_pulses", q_rise.size() - base, 32'd0);
        t = 0;
`endif

        // reset during E high at sel 12
        buffer_ready = 1'b1; @(negedge clk);
        buffer_ready = 1'b0; @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (sel == 6'd12 && lcd_e) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_sel12_e", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_lcd_e", lcd_e, 1'b0);
        chk("abort_sel", sel, 6'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_init_done", init_done, 1'b0);
        chk("abort_lcd_db", lcd_db, 8'h00);
        @(negedge clk);
        rst  = 1'b0;
        rel  = cyc;
        base = q_rise.size();
        check_init(base, rel);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
Name: lcd_frame_writer

Overview:
- Downstream stage of command_lookup.
- Walks `sel` through 0..33 and captures each returned byte on `data_in`.
- Drives each byte onto an HD44780-compatible 2x16 character LCD over an 8-bit parallel bus, with power-on initialisation and all bus timing generated in clock cycles.
- A frame is rewritten whenever `buffer_ready` rises.

Parameters:
- `T_PWR`, 1_500_000, cycles to wait after reset before the first init command (15 ms at 100 MHz).
- `T_AS`, 8, RS/DB setup cycles before E rises.
- `T_EH`, 50, E high-time cycles.
- `T_GAP`, 4_000, post-write wait cycles for normal commands and characters (40 us).
- `T_CLR`, 164_000, post-write wait cycles after the clear command 0x01.
- `SEL_LAT`, 2, cycles from a `sel` change until `data_in` is valid.
- `SEL_LAST`, 33, final `sel` index of a frame.
- `T_REF`, 10_000_000, auto-refresh period in cycles (optional feature only).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  8  byte from command_lookup `data_out` for the current `sel`.
- `buffer_ready`  in  1  command_lookup has new content; the block reacts to the rising edge.
- `sel`  out  6  index presented to command_lookup.
- `lcd_rs`  out  1  0 = command, 1 = character data.
- `lcd_rw`  out  1  tied 0 (write only).
- `lcd_e`  out  1  LCD enable strobe.
- `lcd_db`  out  8  LCD data bus.
- `init_done`  out  1  high once initialisation has completed.
- `busy`  out  1  high while a frame is being written.
- `frame_done`  out  1  one-cycle pulse after `sel == SEL_LAST` has been written.

Behaviour:
- Reset, while `rst` is high: all outputs are 0; FSM goes to `PWR_WAIT`; the wait counter and pending flag are cleared.
  - Reset asserted mid-operation aborts immediately.
  - `lcd_e` drops the same cycle.
  - The full init sequence reruns after reset is released.
- Wait counter: 21 bits, loaded with a delay value and counted down to 0. All waits are exact; the transition happens on the cycle the counter reads 0.
- FSM states: `PWR_WAIT`, `INIT`, `IDLE`, `SEL_SET`, `FETCH`, `SETUP`, `E_HI`, `HOLD`, `NEXT`.
- `PWR_WAIT` -> `INIT` after `T_PWR` cycles.
- `INIT` issues the ROM sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with `lcd_rs = 0`.
  - Each write runs `SETUP` -> `E_HI` -> `HOLD`.
  - The post-write gap is `T_CLR` after 0x01 and `T_GAP` otherwise.
  - After 0x06, `init_done` goes to 1 and the FSM goes to `IDLE`. `init_done` stays 1 until reset.
- Write cycle:
  - `SETUP` holds `lcd_rs` and `lcd_db` stable for `T_AS` cycles with `lcd_e = 0`.
  - `E_HI` holds `lcd_e = 1` for `T_EH` cycles.
  - `HOLD` holds `lcd_e = 0` for the gap time, with `lcd_db` and `lcd_rs` unchanged.
- Frame:
  - `IDLE` with the pending flag set: clear the flag, set `busy = 1`, `sel = 0`, go to `SEL_SET`.
  - `FETCH` waits `SEL_LAT` cycles, then registers `data_in` into the `lcd_db` holding register.
  - `lcd_rs` is 0 for `sel` 0 and 17 (DDRAM address commands 0x80 and 0xC0) and 1 for every other index.
  - `NEXT`: if `sel == SEL_LAST`, set `sel = 0`, pulse `frame_done`, clear `busy`, go to `IDLE`. Otherwise `sel` increments by 1 and the FSM returns to `SEL_SET`.
  - `sel` never exceeds `SEL_LAST`.
- `buffer_ready` handling:
  - A rising edge at any time sets the pending flag; this includes edges during init and mid-frame.
  - The current frame always completes; exactly one follow-up frame runs no matter how many edges occurred.
  - An edge on the same cycle the flag is being cleared in `IDLE` re-sets it.
  - `buffer_ready` held high produces no repeat frames.
- First frame: one frame is automatically pending after init, so the display is never left blank.

Optional Feature:
- Macro `LCD_AUTO_REFRESH_EN`.
- Defined:
  - A 24-bit refresh counter, active only in `IDLE`, sets the pending flag every `T_REF` cycles.
  - The counter restarts on every frame start.
- Undefined: frames start only on a `buffer_ready` rising edge or on the post-init first frame. No refresh counter logic is present.

Decomposition:
- Shared package `lcd_pkg`:
  - FSM state encoding.
  - Init ROM contents and count of 6.
  - Command constants `LCD_CLR` = 0x01, `LCD_LINE1` = 0x80, `LCD_LINE2` = 0xC0.
  - Line-2 index 17.
- One sub-module, `lcd_bus_strobe`. It takes `start`, `rs`, `db` and `gap_sel`, runs the `SETUP`/`E_HI`/`HOLD` timing, and returns a one-cycle `done` pulse. The top level holds the init/frame sequencing.

Test Plan (use `T_PWR=20`, `T_AS=2`, `T_EH=4`, `T_GAP=10`, `T_CLR=30` unless stated):
- Init: release `rst` at t0 -> first `lcd_e` rise at cycle 20+2. There are 6 `lcd_e` pulses with `lcd_db` = 38, 38, 38, 0C, 01, 06 and `lcd_rs = 0`. `lcd_e` high for exactly 4 cycles each. The gap after 01 is 30 cycles. `init_done` = 1 afterwards.
- Auto first frame: a model command_lookup returns `sel+0x40` -> 34 pulses.
  - `lcd_rs = 0` at `sel` 0 and 17, `lcd_rs = 1` otherwise.
  - `lcd_db` matches the model byte for each `sel`.
  - `frame_done` pulses once and `sel` returns to 0.
- Mid-frame `buffer_ready`: 3 rising edges during `sel` 5..10 -> the current frame finishes, then exactly one more frame of 34 pulses, then `IDLE`.
- `buffer_ready` held high for 1000 cycles -> exactly one frame.
- Reset at `sel = 12` while `lcd_e = 1` -> next cycle `lcd_e = 0`, `sel = 0`, `busy = 0`, `init_done = 0`. The init sequence fully repeats.
- With `LCD_AUTO_REFRESH_EN`, `T_REF=500` -> a new frame starts 500 cycles after each `frame_done` with no `buffer_ready` activity.
